fpu_sp_f2i: RTL

FPU_SP_F2I -- requirements
Module: fpu_sp_f2i

---
 rtl/fpu_sp_pkg.sv | 25 ++
 rtl/fpu_sp_f2i.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fpu_sp_pkg.sv
// rtl/fpu_sp_pkg.sv - shared types and constants for the single-precision FPU blocks
package fpu_sp_pkg;

   typedef enum logic [2:0] {
      WAIT_REQ = 3'd0,
      UNPACK   = 3'd1,
      SPECIAL  = 3'd2,
      ALIGN    = 3'd3,
      PACK     = 3'd4,
      OUT_RDY  = 3'd5
   } f2i_state_e;

   localparam logic signed [9:0] EXP_BIAS   = 10'sd127;
   localparam logic signed [9:0] EXP_INT_HI = 10'sd31;
   localparam logic [31:0]       INT32_MAX  = 32'h7FFF_FFFF;
   localparam logic [31:0]       INT32_MIN  = 32'h8000_0000;
   localparam logic [31:0]       QNAN       = 32'h7FC0_0000;
   // The only float with e>=31 that still fits an int32: exactly -2^31.
   localparam logic [31:0]       FP_INT32_MIN = 32'hCF00_0000;

   function automatic logic [31:0] sat_int32(input logic neg);
      return neg ? INT32_MIN : INT32_MAX;
   endfunction

endpackage

// File: rtl/fpu_sp_f2i.sv
// rtl/fpu_sp_f2i.sv - multi-cycle float32 to int32 converter, round-toward-zero
module fpu_sp_f2i
   import fpu_sp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] din,
   input  logic        dval,
   output logic [31:0] result,
   output logic        rdy,
   output logic        nv,
   output logic        nx
);

   f2i_state_e state_q, state_d;

   logic [31:0]       din_q;
   logic              sign_q;
   logic signed [9:0] e_q;
   logic [31:0]       m_q;
   logic              sticky_q;
   logic              special_q;
   logic [31:0]       res_q;
   logic              nv_q;
   logic              nx_q;

   logic exp_max;
   logic e_big;
   logic e_neg;
   logic is_int_min;
   logic is_nan;

   assign exp_max    = (din_q[30:23] == 8'hFF);
   assign is_nan     = exp_max && (din_q[22:0] != 23'd0);
   assign e_big      = (e_q >= EXP_INT_HI);
   assign e_neg      = e_q[9];
   assign is_int_min = (din_q == FP_INT32_MIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= WAIT_REQ;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_REQ: if (dval) state_d = UNPACK;
         UNPACK:   state_d = SPECIAL;
         SPECIAL: begin
            if (exp_max)                state_d = PACK;
            else if (e_big)             state_d = is_int_min ? ALIGN : PACK;
            else if (e_neg)             state_d = PACK;
            else                        state_d = ALIGN;
         end
         ALIGN:    if (e_q == EXP_INT_HI) state_d = PACK;
         PACK:     state_d = OUT_RDY;
         OUT_RDY:  state_d = WAIT_REQ;
         default:  state_d = WAIT_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_q     <= '0;
         sign_q    <= 1'b0;
         e_q       <= '0;
         m_q       <= '0;
         sticky_q  <= 1'b0;
         special_q <= 1'b0;
         res_q     <= '0;
         nv_q      <= 1'b0;
         nx_q      <= 1'b0;
         result    <= '0;
         nv        <= 1'b0;
         nx        <= 1'b0;
         rdy       <= 1'b0;
      end else begin
         rdy <= (state_q == OUT_RDY);
         case (state_q)
            WAIT_REQ: begin
               if (dval) din_q <= din;
            end
            UNPACK: begin
               sign_q <= din_q[31];
               e_q    <= $signed({2'b00, din_q[30:23]}) - EXP_BIAS;
               m_q    <= {1'b1, din_q[22:0], 8'h00};
            end
            SPECIAL: begin
               special_q <= 1'b1;
               sticky_q  <= 1'b0;
               nv_q      <= 1'b0;
               nx_q      <= 1'b0;
               if (exp_max) begin
                  nv_q  <= 1'b1;
                  res_q <= is_nan ? INT32_MAX : sat_int32(sign_q);
               end else if (e_big) begin
                  if (is_int_min) begin
                     special_q <= 1'b0;
                  end else begin
                     nv_q  <= 1'b1;
                     res_q <= sat_int32(sign_q);
                  end
               end else if (e_neg) begin
                  res_q <= '0;
                  nx_q  <= (din_q[30:0] != 31'd0);
               end else begin
                  special_q <= 1'b0;
               end
            end
            ALIGN: begin
               // One bit per cycle; the binary point ends just right of m_q[0] at e=31.
               if (e_q < EXP_INT_HI) begin
                  m_q      <= {1'b0, m_q[31:1]};
                  sticky_q <= sticky_q | m_q[0];
                  e_q      <= e_q + 10'sd1;
               end
            end
            PACK: begin
               if (!special_q) begin
                  res_q <= sign_q ? (~m_q + 32'd1) : m_q;
                  nx_q  <= sticky_q;
                  nv_q  <= 1'b0;
               end
            end
            OUT_RDY: begin
               result <= res_q;
               nv     <= nv_q;
               nx     <= nx_q;
            end
            default: ;
         endcase
      end
   end

endmodule
